// File: rtl/hangman_guess_checker.sv
// Hangman guess checker: holds a six-letter secret word, checks one guessed
// letter at a time, strobes per-slot reveals and tracks lives, win and loss.
module hangman_guess_checker #(
  parameter int unsigned LIVES    = 6,
  parameter int unsigned LETTER_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  word_load,
  input  logic [6*LETTER_W-1:0] word_in,
  input  logic [LETTER_W-1:0]   guess,
  input  logic                  guess_valid,
  output logic                  guess_ready,
  output logic [LETTER_W-1:0]   slot_a,
  output logic [LETTER_W-1:0]   slot_b,
  output logic [LETTER_W-1:0]   slot_c,
  output logic [LETTER_W-1:0]   slot_d,
  output logic [LETTER_W-1:0]   slot_e,
  output logic [LETTER_W-1:0]   slot_f,
  output logic [5:0]            hit,
  output logic [5:0]            revealed,
  output logic                  miss,
  output logic                  dup,
  output logic [3:0]            lives,
  output logic                  win,
  output logic                  lose
);

  localparam int unsigned NSLOT  = 6;
  localparam int unsigned MASK_W = 1 << LETTER_W;
  localparam logic [LETTER_W-1:0] MAX_LETTER = LETTER_W'(26);
  localparam logic [3:0]          LIVES_INIT = 4'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK,
    S_WON,
    S_LOST
  } state_t;

  state_t                  r_state;
  logic [NSLOT*LETTER_W-1:0] r_word;     // bit group j drives hit/revealed bit j
  logic [LETTER_W-1:0]     r_guess;
  logic [MASK_W-1:0]       r_guessed;  // one bit per letter code already tried
  logic [5:0]              r_hit;
  logic [5:0]              r_revealed;
  logic                    r_miss;
  logic                    r_dup;
  logic [3:0]              r_lives;
  logic                    r_win;
  logic                    r_lose;
  logic                    r_ready;

  logic [5:0]              w_match;
  logic [5:0]              w_nz;
  logic [5:0]              w_load_nz;
  logic [5:0]              w_rev_next;
  logic [3:0]              w_lives_next;
  logic                    w_seen;
  logic                    w_guess_ok;
  logic                    w_all_rev;

  // Per-slot compare of the latched guess and non-empty slot masks
  always_comb begin
    w_match   = '0;
    w_nz      = '0;
    w_load_nz = '0;
    for (int j = 0; j < NSLOT; j++) begin
      w_nz[j]      = (r_word[j*LETTER_W +: LETTER_W] != '0);
      w_match[j]   = w_nz[j] && (r_word[j*LETTER_W +: LETTER_W] == r_guess);
      w_load_nz[j] = (word_in[j*LETTER_W +: LETTER_W] != '0);
    end
  end

  assign w_seen     = r_guessed[r_guess];
  assign w_guess_ok = (guess != '0) && (guess <= MAX_LETTER);

  // Outcome of the guess under check: new revealed mask and remaining lives
  always_comb begin
    w_rev_next   = r_revealed;
    w_lives_next = r_lives;
    if (!w_seen) begin
      w_rev_next = r_revealed | w_match;
      if (w_match == '0) begin
        w_lives_next = r_lives - 4'd1;
      end
    end
  end

  assign w_all_rev = ((w_rev_next & w_nz) == w_nz);

  // Game FSM with registered results; pulses default low every edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_guess    <= '0;
      r_guessed  <= '0;
      r_hit      <= '0;
      r_revealed <= '0;
      r_miss     <= 1'b0;
      r_dup      <= 1'b0;
      r_lives    <= '0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_hit  <= '0;
      r_miss <= 1'b0;
      r_dup  <= 1'b0;
      if (word_load) begin
        r_word     <= word_in;
        r_revealed <= '0;
        r_guessed  <= '0;
        r_win      <= 1'b0;
        r_lose     <= 1'b0;
        if (w_load_nz != '0) begin
          r_state <= S_PLAY;
          r_lives <= LIVES_INIT;
          r_ready <= 1'b1;
        end else begin
          // An all-empty word cannot be played
          r_state <= S_IDLE;
          r_lives <= '0;
          r_ready <= 1'b0;
        end
      end else begin
        case (r_state)
          S_PLAY: begin
            if (guess_valid && w_guess_ok) begin
              r_guess <= guess;
              r_state <= S_CHECK;
              r_ready <= 1'b0;
            end
          end
          S_CHECK: begin
            r_guessed[r_guess] <= 1'b1;
            r_revealed         <= w_rev_next;
            r_lives            <= w_lives_next;
            if (w_seen) begin
              r_dup <= 1'b1;
            end else if (w_match != '0) begin
              r_hit <= w_match;
            end else begin
              r_miss <= 1'b1;
            end
            if (w_all_rev) begin
              r_state <= S_WON;
              r_win   <= 1'b1;
            end else if (w_lives_next == '0) begin
              r_state <= S_LOST;
              r_lose  <= 1'b1;
            end else begin
              r_state <= S_PLAY;
              r_ready <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign guess_ready = r_ready;
  assign slot_a      = r_word[5*LETTER_W +: LETTER_W];
  assign slot_b      = r_word[4*LETTER_W +: LETTER_W];
  assign slot_c      = r_word[3*LETTER_W +: LETTER_W];
  assign slot_d      = r_word[2*LETTER_W +: LETTER_W];
  assign slot_e      = r_word[1*LETTER_W +: LETTER_W];
  assign slot_f      = r_word[0*LETTER_W +: LETTER_W];
  assign hit         = r_hit;
  assign revealed    = r_revealed;
  assign miss        = r_miss;
  assign dup         = r_dup;
  assign lives       = r_lives;
  assign win         = r_win;
  assign lose        = r_lose;

endmodule
